// File: rtl/capture_sequencer.sv
// capture_sequencer: frame-level capture controller. It gates a spectrum
// AXI-Stream so that only whole frames (tuser = first beat, tlast = last beat)
// reach the analysis stage. An AHB-Lite register bank programs the frame count,
// the skip count and single/continuous mode, and raises a completion interrupt.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   tdata_s/tuser_s/tlast_s/tvalid_s     upstream stream in, tready_s out
//   tdata_m/tuser_m/tlast_m/tvalid_m     downstream stream out, tready_m in
//   haddr_s..hsel_s                      AHB-Lite slave inputs
//   hrdata_s, hreadyout_s, hresp_s       AHB-Lite slave outputs
//   interrupt                            done & IRQ_EN
module capture_sequencer #(
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] tdata_s,
    input  logic          tuser_s,
    input  logic          tlast_s,
    input  logic          tvalid_s,
    output logic          tready_s,
    output logic [DW-1:0] tdata_m,
    output logic          tuser_m,
    output logic          tlast_m,
    output logic          tvalid_m,
    input  logic          tready_m,
    input  logic [31:0]   haddr_s,
    input  logic [2:0]    hburst_s,
    input  logic [2:0]    hsize_s,
    input  logic [1:0]    htrans_s,
    input  logic [31:0]   hwdata_s,
    input  logic          hwrite_s,
    input  logic          hsel_s,
    output logic [31:0]   hrdata_s,
    output logic          hreadyout_s,
    output logic          hresp_s,
    output logic          interrupt
);

    localparam int unsigned RAW = 3;
    localparam int unsigned HW  = 32;

    localparam logic [RAW-1:0] REG_CTRL   = 3'd0;
    localparam logic [RAW-1:0] REG_STATUS = 3'd1;
    localparam logic [RAW-1:0] REG_FRAMES = 3'd2;
    localparam logic [RAW-1:0] REG_SKIP   = 3'd3;
    localparam logic [RAW-1:0] REG_CAPT   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_PASS = 2'd2,
        ST_SKIP = 2'd3
    } state_t;

    state_t         state;
    logic           cont;
    logic           irq_en;
    logic           done;
    logic           stopped;
    logic           stop_pend;
    logic [CW-1:0]  frames_reg;
    logic [CW-1:0]  skip_reg;
    logic [CW-1:0]  captured;
    logic [CW-1:0]  remain;
    logic [CW-1:0]  skipcnt;

    // AHB address phase, held for the following data phase
    logic           ph_valid;
    logic           ph_write;
    logic [RAW-1:0] ph_addr;

    logic           wr_en;
    logic           wr_ctrl;
    logic           wr_status;
    logic           start_req;
    logic           stop_req;
    logic           stop_any;
    logic           busy;
    logic           hs;
    logic           frame_end;
    logic [CW-1:0]  frames_eff;
    logic [CW-1:0]  captured_inc;
    logic [CW-1:0]  rem_dec;
    logic           fe_last;
    logic [CW-1:0]  fe_remain;
    state_t         fe_next;

    logic           unused_bits;
    assign unused_bits = ^{hburst_s, hsize_s, htrans_s[0], haddr_s[31:5],
                           haddr_s[1:0], hwdata_s};

    // Data-phase write decode; STOP overrides a simultaneous START
    assign wr_en     = ph_valid & ph_write;
    assign wr_ctrl   = wr_en & (ph_addr == REG_CTRL);
    assign wr_status = wr_en & (ph_addr == REG_STATUS);
    assign start_req = wr_ctrl & hwdata_s[0] & ~hwdata_s[1];
    assign stop_req  = wr_ctrl & hwdata_s[1];
    assign stop_any  = stop_pend | stop_req;
    assign busy      = (state != ST_IDLE);

    // Stream gating: ARM forwards only frame-start beats, PASS forwards everything
    always_comb begin
        tvalid_m = 1'b0;
        tready_s = 1'b1;
        case (state)
            ST_ARM: begin
                if (tuser_s) begin
                    tvalid_m = tvalid_s;
                    tready_s = tready_m;
                end
            end
            ST_PASS: begin
                tvalid_m = tvalid_s;
                tready_s = tready_m;
            end
            default: ;
        endcase
    end

    assign tdata_m = tdata_s;
    assign tuser_m = tuser_s;
    assign tlast_m = tlast_s;
    assign hs      = tvalid_s & tready_s;

    assign frame_end = hs & tlast_s &
                       (((state == ST_ARM) & tuser_s) | (state == ST_PASS));

    // Frame-end bookkeeping: counters never wrap, CAPTURED saturates
    always_comb begin
        frames_eff   = (frames_reg == '0) ? CW'(1) : frames_reg;
        captured_inc = (&captured) ? captured : captured + CW'(1);
        rem_dec      = (remain == '0) ? '0 : remain - CW'(1);
        fe_last      = (rem_dec == '0);
        fe_remain    = (fe_last && cont) ? frames_eff : rem_dec;
        if (stop_any || (fe_last && !cont)) begin
            fe_next = ST_IDLE;
        end else if (skip_reg != '0) begin
            fe_next = ST_SKIP;
        end else begin
            fe_next = ST_ARM;
        end
    end

    // Register bank and sequencer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cont       <= 1'b0;
            irq_en     <= 1'b0;
            done       <= 1'b0;
            stopped    <= 1'b0;
            stop_pend  <= 1'b0;
            frames_reg <= '0;
            skip_reg   <= '0;
            captured   <= '0;
            remain     <= '0;
            skipcnt    <= '0;
            ph_valid   <= 1'b0;
            ph_write   <= 1'b0;
            ph_addr    <= '0;
        end else begin
            ph_valid <= hsel_s & htrans_s[1];
            ph_write <= hwrite_s;
            ph_addr  <= haddr_s[4:2];

            if (wr_ctrl) begin
                cont   <= hwdata_s[2];
                irq_en <= hwdata_s[3];
            end
            if (wr_en && (ph_addr == REG_FRAMES)) frames_reg <= hwdata_s[CW-1:0];
            if (wr_en && (ph_addr == REG_SKIP))   skip_reg   <= hwdata_s[CW-1:0];

            // W1C first so a same-cycle set below takes priority
            if (wr_status && hwdata_s[1]) done    <= 1'b0;
            if (wr_status && hwdata_s[2]) stopped <= 1'b0;

            if (frame_end) begin
                captured  <= captured_inc;
                remain    <= fe_remain;
                skipcnt   <= skip_reg;
                stop_pend <= 1'b0;
                state     <= fe_next;
                if (fe_last)  done    <= 1'b1;
                if (stop_any) stopped <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_req) begin
                            remain    <= frames_eff;
                            captured  <= '0;
                            stop_pend <= 1'b0;
                            state     <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        // A frame already started this cycle is finished before stopping
                        if (hs && tuser_s) begin
                            stop_pend <= stop_any;
                            state     <= ST_PASS;
                        end else if (stop_any) begin
                            stop_pend <= 1'b0;
                            stopped   <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                    ST_PASS: begin
                        if (stop_req) stop_pend <= 1'b1;
                    end
                    ST_SKIP: begin
                        if (stop_any) begin
                            stop_pend <= 1'b0;
                            stopped   <= 1'b1;
                            state     <= ST_IDLE;
                        end else if (hs && tlast_s) begin
                            if (skipcnt <= CW'(1)) begin
                                skipcnt <= '0;
                                state   <= ST_ARM;
                            end else begin
                                skipcnt <= skipcnt - CW'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Read data in the data phase from current register values
    always_comb begin
        hrdata_s = '0;
        if (ph_valid && !ph_write) begin
            case (ph_addr)
                REG_CTRL:   hrdata_s = HW'({irq_en, cont, 2'b00});
                REG_STATUS: hrdata_s = HW'({state, 1'b0, stopped, done, busy});
                REG_FRAMES: hrdata_s = HW'(frames_reg);
                REG_SKIP:   hrdata_s = HW'(skip_reg);
                REG_CAPT:   hrdata_s = HW'(captured);
                default:    hrdata_s = '0;
            endcase
        end
    end

    assign hreadyout_s = 1'b1;
    assign hresp_s     = 1'b0;
    assign interrupt   = done & irq_en;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: randomized frame source and sink,
// AHB register traffic, and a behavioural model compared on every cycle.
module tb_capture_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam int P_IDLE = 0, P_ARM = 1, P_PASS = 2, P_SKIP = 3;
    localparam int CAP_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [DW-1:0] tdata_s;
    logic          tuser_s, tlast_s, tvalid_s, tready_s;
    logic [DW-1:0] tdata_m;
    logic          tuser_m, tlast_m, tvalid_m, tready_m;
    logic [31:0]   haddr_s, hwdata_s, hrdata_s;
    logic [2:0]    hburst_s, hsize_s;
    logic [1:0]    htrans_s;
    logic          hwrite_s, hsel_s, hreadyout_s, hresp_s, interrupt;

    capture_sequencer #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .tdata_s(tdata_s), .tuser_s(tuser_s), .tlast_s(tlast_s),
        .tvalid_s(tvalid_s), .tready_s(tready_s),
        .tdata_m(tdata_m), .tuser_m(tuser_m), .tlast_m(tlast_m),
        .tvalid_m(tvalid_m), .tready_m(tready_m),
        .haddr_s(haddr_s), .hburst_s(hburst_s), .hsize_s(hsize_s),
        .htrans_s(htrans_s), .hwdata_s(hwdata_s), .hwrite_s(hwrite_s),
        .hsel_s(hsel_s), .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s),
        .hresp_s(hresp_s), .interrupt(interrupt)
    );

    initial forever #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    // Model of the controller, in terms of the documented rules
    int   m_phase, m_frames, m_skip, m_capt, m_remain, m_skipleft, m_ph_addr;
    logic m_cont, m_irq, m_done, m_stopped, m_stop_pend, m_ph_valid, m_ph_write;

    // Source / sink state and observation counters
    int   src_idx = 0, frame_len = 8, next_len = 8;
    int   valid_pct = 70, ready_pct = 80, hold_low = 0;
    logic last_hs = 1'b0;
    int   fwd_beats = 0, fwd_frames = 0, stall_cycles = 0;
    logic [31:0] last_rd = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_frames = 0; m_skip = 0; m_capt = 0; m_remain = 0;
        m_skipleft = 0; m_ph_addr = 0; m_cont = 0; m_irq = 0; m_done = 0;
        m_stopped = 0; m_stop_pend = 0; m_ph_valid = 0; m_ph_write = 0;
    endtask

    function automatic logic [31:0] model_read(int a);
        case (a)
            0: return {28'd0, m_irq, m_cont, 2'd0};
            1: return {26'd0, 2'(m_phase), 1'b0, m_stopped, m_done, (m_phase != P_IDLE)};
            2: return 32'(m_frames);
            3: return 32'(m_skip);
            4: return 32'(m_capt);
            default: return 32'd0;
        endcase
    endfunction

    task automatic end_of_frame(int target, logic cont, int skip, logic stop_now);
        if (m_capt < CAP_MAX) m_capt++;
        m_remain--;
        if (m_remain == 0) begin
            m_done = 1;
            if (cont) m_remain = target;
        end
        m_stop_pend = 0;
        if (stop_now) m_stopped = 1;
        if (stop_now || m_remain == 0) m_phase = P_IDLE;
        else if (skip > 0) begin m_skipleft = skip; m_phase = P_SKIP; end
        else m_phase = P_ARM;
    endtask

    task automatic model_edge();
        logic fwd, hs, wr, ctrl_wr, start, stop, stop_now, old_cont;
        int target, old_skip, a;
        if (!reset_n) begin model_reset(); last_hs = tvalid_s; return; end
        fwd = (m_phase == P_PASS) || (m_phase == P_ARM && tuser_s);
        hs = tvalid_s && (fwd ? tready_m : 1'b1);
        last_hs = hs;
        wr = m_ph_valid && m_ph_write;
        a = m_ph_addr;
        ctrl_wr = wr && (a == 0);
        start = ctrl_wr && hwdata_s[0] && !hwdata_s[1];
        stop = ctrl_wr && hwdata_s[1];
        target = (m_frames == 0) ? 1 : m_frames;
        old_cont = m_cont;
        old_skip = m_skip;
        stop_now = m_stop_pend || stop;
        if (wr && a == 1) begin
            if (hwdata_s[1]) m_done = 0;
            if (hwdata_s[2]) m_stopped = 0;
        end
        case (m_phase)
            P_IDLE: if (start) begin m_remain = target; m_capt = 0; m_phase = P_ARM; end
            P_ARM: begin
                if (hs && tuser_s) begin
                    if (tlast_s) end_of_frame(target, old_cont, old_skip, stop_now);
                    else begin m_phase = P_PASS; m_stop_pend = stop_now; end
                end else if (stop_now) begin
                    m_phase = P_IDLE; m_stopped = 1;
                end
            end
            P_PASS: begin
                if (hs && tlast_s) end_of_frame(target, old_cont, old_skip, stop_now);
                else if (stop) m_stop_pend = 1;
            end
            default: begin
                if (stop_now) begin m_phase = P_IDLE; m_stopped = 1; end
                else if (hs && tlast_s) begin
                    m_skipleft--;
                    if (m_skipleft == 0) m_phase = P_ARM;
                end
            end
        endcase
        if (m_phase == P_IDLE) m_stop_pend = 0;
        if (ctrl_wr) begin m_cont = hwdata_s[2]; m_irq = hwdata_s[3]; end
        if (wr && a == 2) m_frames = int'(hwdata_s[CW-1:0]);
        if (wr && a == 3) m_skip = int'(hwdata_s[CW-1:0]);
        m_ph_valid = hsel_s && htrans_s[1];
        m_ph_write = hwrite_s;
        m_ph_addr  = int'(haddr_s[4:2]);
    endtask

    // Per-cycle comparison of every meaningful output against the model
    task automatic compare();
        logic fwd, ev, er;
        fwd = (m_phase == P_PASS) || (m_phase == P_ARM && tuser_s);
        ev = fwd ? tvalid_s : 1'b0;
        er = fwd ? tready_m : 1'b1;
        check("stream_ctl", {tvalid_m, tready_s, interrupt, hreadyout_s, hresp_s},
              {ev, er, m_done & m_irq, 1'b1, 1'b0});
        if (ev) check("stream_data", {tdata_m, tuser_m, tlast_m}, {tdata_s, tuser_s, tlast_s});
        if (m_ph_valid && !m_ph_write) begin
            check($sformatf("read_reg%0d", m_ph_addr), hrdata_s, model_read(m_ph_addr));
            last_rd = hrdata_s;
        end
        if (tvalid_m && tready_m) begin
            fwd_beats++;
            if (tlast_m) fwd_frames++;
        end
        if (!tready_s) stall_cycles++;
    endtask

    task automatic set_beat();
        tdata_s = DW'($urandom);
        tuser_s = (src_idx == 0);
        tlast_s = (src_idx == frame_len - 1);
    endtask

    task automatic source_advance();
        if (tvalid_s && !last_hs) return;
        if (tvalid_s && last_hs) begin
            src_idx++;
            if (src_idx >= frame_len) begin src_idx = 0; frame_len = next_len; end
            set_beat();
        end
        tvalid_s = ($urandom_range(99) < valid_pct);
    endtask

    task automatic sink_advance();
        if (hold_low > 0) begin tready_m = 1'b0; hold_low--; end
        else tready_m = ($urandom_range(99) < ready_pct);
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
        source_advance();
        sink_advance();
    endtask

    task automatic ahb_idle();
        hsel_s = 1'($urandom);
        htrans_s = {1'b0, 1'($urandom)};
        hwrite_s = 1'($urandom);
        haddr_s = $urandom;
    endtask

    task automatic ahb_addr(int addr, logic wr);
        hsel_s = 1'b1;
        htrans_s = 2'b10;
        haddr_s = ($urandom & ~32'h1f) | 32'(addr);
        hwrite_s = wr;
        hburst_s = 3'($urandom);
        hsize_s = 3'($urandom);
    endtask

    task automatic ahb_write(int addr, logic [31:0] d);
        ahb_addr(addr, 1'b1);
        tick();
        ahb_idle();
        hwdata_s = d;
        tick();
        hwdata_s = $urandom;
    endtask

    task automatic ahb_read(int addr);
        ahb_addr(addr, 1'b0);
        tick();
        ahb_idle();
        tick();
    endtask

    task automatic wait_phase(int ph, int budget, string name);
        int n = 0;
        while (m_phase != ph && n < budget) begin tick(); n++; end
        if (m_phase != ph) begin
            n_total++;
            $display("FAIL %s: timeout waiting for state %0d, now %0d", name, ph, m_phase);
        end
    endtask

    task automatic wait_done(int budget, string name);
        int n = 0;
        while (!m_done && n < budget) begin tick(); n++; end
        if (!m_done) begin
            n_total++;
            $display("FAIL %s: timeout waiting for done", name);
        end
    endtask

    task automatic wait_src(int idx, int budget, string name);
        int n = 0;
        while (src_idx != idx && n < budget) begin tick(); n++; end
        if (src_idx != idx) begin
            n_total++;
            $display("FAIL %s: timeout waiting for source beat %0d", name, idx);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        ahb_idle();
        hwdata_s = '0;
        #1;
        check("reset_outputs", {tvalid_m, tready_s, interrupt, hreadyout_s, hresp_s}, 5'b01010);
        check("reset_hrdata", hrdata_s, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        set_beat();
        tvalid_s = 1'b0;
        tready_m = 1'b1;
        hburst_s = '0;
        hsize_s = '0;
        hwdata_s = '0;
        ahb_idle();
        #2;
        do_reset();

        // Two frames, START mid-frame: the partial frame is dropped
        ahb_write(8, 2);
        ahb_write(12, 0);
        wait_src(3, 200, "s1_midframe");
        fwd_beats = 0; fwd_frames = 0;
        ahb_write(0, 32'h1);
        check("s1_model_armed", m_phase, P_ARM);
        wait_phase(P_IDLE, 600, "s1_idle");
        check("s1_beats", fwd_beats, 16);
        check("s1_frames", fwd_frames, 2);
        check("s1_model_capt", m_capt, 2);
        ahb_read(16);
        check("s1_captured", last_rd, 32'd2);
        ahb_read(4);
        check("s1_status", last_rd, 32'h2);

        // Three frames with one skipped frame between each
        ahb_write(4, 32'h6);
        ahb_write(8, 3);
        ahb_write(12, 1);
        fwd_beats = 0; fwd_frames = 0;
        ahb_write(0, 32'h1);
        wait_phase(P_IDLE, 1500, "s2_idle");
        check("s2_beats", fwd_beats, 24);
        check("s2_frames", fwd_frames, 3);
        ahb_read(16);
        check("s2_captured", last_rd, 32'd3);

        // Continuous with interrupt, W1C lowers it, next frame re-raises it
        ahb_write(4, 32'h6);
        ahb_write(8, 1);
        ahb_write(12, 0);
        fwd_beats = 0; fwd_frames = 0;
        ahb_write(0, 32'hD);
        wait_done(600, "s3_done1");
        check("s3_irq_rise", interrupt, 1'b1);
        ahb_write(4, 32'h2);
        check("s3_irq_cleared", interrupt, 1'b0);
        check("s3_model_done_cleared", m_done, 1'b0);
        wait_done(600, "s3_done2");
        check("s3_irq_rerise", interrupt, 1'b1);
        check("s3_two_frames", fwd_frames >= 2, 1'b1);
        ahb_write(0, 32'h2);
        wait_phase(P_IDLE, 600, "s3_stop");
        check("s3_whole_frames", fwd_beats % 8, 0);

        // STOP during beat 4 of a frame in PASS: the frame completes
        valid_pct = 100; ready_pct = 100;
        ahb_write(4, 32'h6);
        ahb_write(8, 5);
        fwd_beats = 0; fwd_frames = 0;
        ahb_write(0, 32'h1);
        wait_phase(P_PASS, 200, "s4_pass");
        wait_src(3, 50, "s4_beat4");
        ahb_write(0, 32'h2);
        wait_phase(P_IDLE, 100, "s4_idle");
        check("s4_beats", fwd_beats, 8);
        ahb_read(4);
        check("s4_status", last_rd, 32'h4);
        ahb_read(16);
        check("s4_captured", last_rd, 32'd1);

        // STOP in ARM: IDLE on the next cycle
        ahb_write(4, 32'h6);
        valid_pct = 0;
        repeat (3) tick();
        ahb_write(0, 32'h1);
        check("s4_arm", m_phase, P_ARM);
        repeat (2) tick();
        ahb_write(0, 32'h2);
        check("s4_arm_stop_model", m_phase, P_IDLE);
        ahb_read(4);
        check("s4_arm_status", last_rd, 32'h4);

        // Downstream back-pressure for 5 cycles mid-frame
        valid_pct = 100; ready_pct = 100;
        ahb_write(4, 32'h6);
        ahb_write(8, 1);
        fwd_beats = 0;
        ahb_write(0, 32'h1);
        wait_phase(P_PASS, 200, "s5_pass");
        tick();
        begin
            logic [DW-1:0] held;
            held = tdata_s;
            stall_cycles = 0;
            tready_m = 1'b0;
            hold_low = 4;
            repeat (5) tick();
            check("s5_stall_cycles", stall_cycles, 5);
            check("s5_data_held", tdata_m, held);
        end
        wait_phase(P_IDLE, 100, "s5_idle");
        check("s5_beats", fwd_beats, 8);

        // Reset mid-frame
        ahb_write(8, 2);
        ahb_write(0, 32'h9);
        wait_phase(P_PASS, 200, "s6_pass");
        repeat (2) tick();
        do_reset();
        ahb_read(4);
        check("s6_status", last_rd, 32'd0);
        ahb_read(0);
        check("s6_ctrl", last_rd, 32'd0);

        // Randomized soak with varying frame lengths and register traffic
        valid_pct = 70; ready_pct = 75;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(9))
                0: ahb_write(8, $urandom_range(3));
                1: ahb_write(12, $urandom_range(2));
                2, 3: ahb_write(0, {28'd0, 2'($urandom), 2'b01});
                4: ahb_write(0, {28'd0, 4'($urandom)});
                5: ahb_write(4, $urandom & 32'h6);
                6: ahb_read($urandom_range(7) * 4);
                7: next_len = $urandom_range(1, 8);
                default: repeat ($urandom_range(1, 20)) tick();
            endcase
        end
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Frame-level capture controller between `receiver_compensation` and the analysis modules (`stream_buffer`, `prominence_analysis`). It gates the spectrum AXI-Stream so that only whole frames reach the analysis stage. Frames are aligned on `tuser` (first beat) and `tlast` (last beat). The CPU uses an AHB-Lite register bank to program the number of frames to capture, the number of frames to skip between captures, and single or continuous mode, and receives a completion interrupt.

## Interface
Parameters:
- `DW`, 16: stream sample width.
- `CW`, 16: width of the frame counters.

Ports:
- `clk` in 1: single clock, shared by stream and AHB.
- `reset_n` in 1: asynchronous active-low reset.
- `tdata_s` in DW: upstream spectrum data.
- `tuser_s` in 1: first beat of frame.
- `tlast_s` in 1: last beat of frame.
- `tvalid_s` in 1: upstream valid.
- `tready_s` out 1: upstream ready.
- `tdata_m` out DW: forwarded data.
- `tuser_m` out 1: forwarded first-beat flag.
- `tlast_m` out 1: forwarded last-beat flag.
- `tvalid_m` out 1: downstream valid.
- `tready_m` in 1: downstream ready.
- `haddr_s` in 32, `hburst_s` in 3, `hsize_s` in 3, `htrans_s` in 2, `hwdata_s` in 32, `hwrite_s` in 1, `hsel_s` in 1: AHB-Lite slave inputs.
- `hrdata_s` out 32, `hreadyout_s` out 1, `hresp_s` out 1: AHB-Lite slave outputs.
- `interrupt` out 1: level interrupt, equal to `done & IRQ_EN`.

## Operation
- Registers are word-addressed by `haddr_s[4:2]`:
  - 0x00 CTRL: bit0 START (write-1 pulse), bit1 STOP (write-1 pulse), bit2 CONT, bit3 IRQ_EN. Readback returns CONT and IRQ_EN only.
  - 0x04 STATUS: bit0 busy (state≠IDLE), bit1 done (sticky, write-1-to-clear), bit2 stopped (sticky, write-1-to-clear), bits[5:4] state code.
  - 0x08 FRAMES: CW bits, frames per capture. A value of 0 is treated as 1.
  - 0x0C SKIP: CW bits, frames discarded between frames in a capture.
  - 0x10 CAPTURED: read-only count of frames forwarded since the last START.
  - Other offsets read 0 and ignore writes.
- A transfer is valid when `hsel_s & htrans_s[1]`. Address and write are registered in the address phase; the register is written from `hwdata_s` in the data phase. `hburst_s` and `hsize_s` are ignored; every access is treated as 32-bit.
- Stream gating is combinational:
  - Forward mode: `tvalid_m=tvalid_s`, `tready_s=tready_m`, data/user/last passed through.
  - Drop mode: `tvalid_m=0`, `tready_s=1`.
- An upstream handshake ("hs") is `tvalid_s & tready_s`.
- State codes: IDLE=0, ARM=1, PASS=2, SKIP=3.
  - IDLE: drop mode. START loads `remain=max(FRAMES,1)`, clears CAPTURED, goes to ARM. START while busy is ignored.
  - ARM: a beat with `tuser_s=1` is forwarded; every other beat is dropped. An hs on a tuser beat goes to PASS, or directly to frame-end handling if `tlast_s` is also set.
  - PASS: forward mode. An hs with `tlast_s` is a frame end.
  - SKIP: drop mode. An hs with `tlast_s` decrements `skipcnt`. When `skipcnt` reaches 0, go to ARM.
- Frame end (from ARM or PASS), evaluated in this order:
  1. CAPTURED+1 and `remain`−1.
  2. If `remain` becomes 0 and CONT=0: set done, go to IDLE.
  3. If `remain` becomes 0 and CONT=1: reload `remain`, set done, continue.
  4. To continue: if SKIP>0, load `skipcnt=SKIP` and go to SKIP; otherwise go to ARM.
- STOP sets `stop_pend`:
  - In IDLE: ignored.
  - In ARM or SKIP: go to IDLE next cycle, set stopped.
  - In PASS: finish the current frame, then go to IDLE and set stopped. Done is not set unless that frame completes the count.
- START and STOP written together: STOP wins, START is ignored.
- CAPTURED saturates at all-ones. `remain` and `skipcnt` never wrap.

## Timing
- Stream path latency is 0 cycles and combinational; no beat is duplicated or lost in forward mode.
- `hreadyout_s` is always 1 and `hresp_s` is always 0 (OKAY).
- Read data is valid in the data phase from the current register values.
- A CTRL write whose data phase is in cycle N changes state at the edge ending cycle N, so the state is visible in cycle N+1.
- Done is set on the edge of the frame-end hs. `interrupt` rises the same cycle and stays high until STATUS bit1 is cleared with write-1 or IRQ_EN is cleared.
- A done set and a W1C in the same cycle: the set wins.
- Reset values:
  - All registers 0, state IDLE.
  - `tvalid_m=0`, `tready_s=1`, `hrdata_s=0`, `interrupt=0`, `hreadyout_s=1`, `hresp_s=0`.
- Asserting `reset_n` mid-frame aborts immediately. Downstream may see a truncated frame.

## Test plan
- FRAMES=2, SKIP=0, CONT=0, START issued mid-frame with 8-beat frames → the partial frame is dropped; the next 2 complete frames (16 beats) are forwarded; done=1, CAPTURED=2, then IDLE.
- FRAMES=3, SKIP=1 → frames 1, 3 and 5 are forwarded; frames 2 and 4 are dropped with `tready_s=1`; CAPTURED=3.
- CONT=1, FRAMES=1, IRQ_EN=1 → every frame is forwarded; `interrupt` rises after frame 1; W1C STATUS=0x2 lowers it, and it re-rises after the next frame.
- STOP written during beat 4 of 8 in PASS → beats 5–8 are forwarded, then IDLE; stopped=1, done=0. STOP in ARM → IDLE next cycle.
- `tready_m` held low for 5 cycles mid-frame → `tready_s=0` for those cycles and the data is unchanged after release. `reset_n` pulsed mid-frame → all outputs return to reset values and STATUS=0.
